ram_1rw1w_port_ctrl: RTL and testbench

Initiator-side controller for the two-port synchronous RAM (port 0 read-or-write, port 1 write-only, 1-cycle read latency). It accepts independent valid/ready read and write request streams from a TCP datapath engine and round-robin arbitrates reads against port-0 writes. It drives the RAM port signals, captures read data one cycle later into a credit-protected response FIFO, and returns responses over a valid/ready stream that honours downstream backpressure.

---
 rtl/ram_1rw1w_port_ctrl_pkg.sv | 12 +
 rtl/ram_resp_fifo.sv | 74 +++++++
 rtl/ram_resp_fifo_chk.sv | 15 +
 rtl/ram_1rw1w_port_ctrl.sv | 111 +++++++++++
 tb/tb_ram_1rw1w_port_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_1rw1w_port_ctrl_pkg.sv
// Shared constants and helpers for the two-port RAM initiator and its response FIFO.
package ram_1rw1w_port_ctrl_pkg;

  localparam logic grant_rd_lp = 1'b0;
  localparam logic grant_wr_lp = 1'b1;

  // Address/pointer width that never collapses to zero bits for a single-entry range.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_resp_fifo.sv
// Circular response FIFO with any depth >= 2 and an occupancy output for credit counting.
module ram_resp_fifo
  import ram_1rw1w_port_ctrl_pkg::*;
#(
  parameter  int width_p      = 8,
  parameter  int els_p        = 4,
  localparam int ptr_width_lp = safe_clog2(els_p),
  localparam int cnt_width_lp = safe_clog2(els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [width_p-1:0]      data_i,
  input  logic                    yumi_i,
  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  output logic [cnt_width_lp-1:0] count_o
);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] wr_ptr_r;
  logic [ptr_width_lp-1:0] rd_ptr_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    pop_s;
  logic                    full_s;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? {ptr_width_lp{1'b0}} : p + ptr_width_lp'(1);
  endfunction

  assign pop_s   = yumi_i && (count_r != {cnt_width_lp{1'b0}});
  assign full_s  = (count_r == cnt_width_lp'(els_p));
  assign v_o     = (count_r != {cnt_width_lp{1'b0}});
  assign data_o  = mem_r[rd_ptr_r];
  assign count_o = count_r;

  // Storage write; the head slot is never the write target while it holds valid data.
  always_ff @(posedge clk_i) begin
    if (v_i && !reset_i) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= {ptr_width_lp{1'b0}};
      rd_ptr_r <= {ptr_width_lp{1'b0}};
      count_r  <= {cnt_width_lp{1'b0}};
    end else begin
      if (v_i) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({v_i, pop_s})
        2'b10:   count_r <= count_r + cnt_width_lp'(1);
        2'b01:   count_r <= count_r - cnt_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  ram_resp_fifo_chk u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (v_i),
    .pop_i   (pop_s),
    .full_i  (full_s)
  );

endmodule

// File: rtl/ram_resp_fifo_chk.sv
// Simulation-only checks on the response FIFO handshake.
module ram_resp_fifo_chk (
  input logic clk_i,
  input logic reset_i,
  input logic push_i,
  input logic pop_i,
  input logic full_i
);

  // The credit scheme must keep a push from ever landing on a full FIFO without a pop.
  push_into_full_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push_i && full_i && !pop_i))
    else $error("ram_resp_fifo: push into full FIFO");

endmodule

// File: rtl/ram_1rw1w_port_ctrl.sv
// Initiator for a 1RW+1W synchronous RAM: arbitrates reads against port-0 writes and
// returns read data through a credit-protected response FIFO.
module ram_1rw1w_port_ctrl
  import ram_1rw1w_port_ctrl_pkg::*;
#(
  parameter  int width_p       = -1,
  parameter  int els_p         = -1,
  parameter  int resp_els_p    = 4,
  localparam int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     rd_req_val_i,
  output logic                     rd_req_rdy_o,
  input  logic [addr_width_lp-1:0] rd_req_addr_i,
  input  logic                     wr0_req_val_i,
  output logic                     wr0_req_rdy_o,
  input  logic [addr_width_lp-1:0] wr0_req_addr_i,
  input  logic [width_p-1:0]       wr0_req_data_i,
  input  logic                     wr1_req_val_i,
  output logic                     wr1_req_rdy_o,
  input  logic [addr_width_lp-1:0] wr1_req_addr_i,
  input  logic [width_p-1:0]       wr1_req_data_i,
  output logic                     rd_resp_val_o,
  input  logic                     rd_resp_rdy_i,
  output logic [width_p-1:0]       rd_resp_data_o,
  output logic                     ram_v0_o,
  output logic                     ram_w0_o,
  output logic [addr_width_lp-1:0] ram_addr0_o,
  output logic [width_p-1:0]       ram_w0_data_o,
  input  logic [width_p-1:0]       ram_r0_data_i,
  output logic                     ram_v1_o,
  output logic                     ram_w1_o,
  output logic [addr_width_lp-1:0] ram_addr1_o,
  output logic [width_p-1:0]       ram_w1_data_o
);

  localparam int cnt_width_lp = safe_clog2(resp_els_p + 1);

  logic                    inflight_r;
  logic                    last_grant_r;
  logic [cnt_width_lp-1:0] fifo_count_s;
  logic [cnt_width_lp:0]   credit_s;
  logic                    rd_elig_s;
  logic                    rd_win_s;
  logic                    wr_win_s;

  // Credits cover both queued and in-flight reads so a captured word always has a slot.
  always_comb begin
    credit_s  = {1'b0, fifo_count_s} + {{cnt_width_lp{1'b0}}, inflight_r};
    rd_elig_s = rd_req_val_i && (credit_s < (cnt_width_lp + 1)'(resp_els_p));
    if (rd_elig_s && wr0_req_val_i) begin
      rd_win_s = (last_grant_r == grant_wr_lp);
    end else begin
      rd_win_s = rd_elig_s;
    end
    wr_win_s = wr0_req_val_i && !rd_win_s;
  end

  // Port-0 drive: the winner owns the address, write data simply rides along.
  always_comb begin
    ram_v0_o      = rd_win_s || wr_win_s;
    ram_w0_o      = wr_win_s;
    ram_w0_data_o = wr0_req_data_i;
    if (wr_win_s) begin
      ram_addr0_o = wr0_req_addr_i;
    end else begin
      ram_addr0_o = rd_req_addr_i;
    end
  end

  assign rd_req_rdy_o  = rd_win_s;
  assign wr0_req_rdy_o = wr_win_s;
  assign wr1_req_rdy_o = 1'b1;
  assign ram_v1_o      = wr1_req_val_i;
  assign ram_w1_o      = wr1_req_val_i;
  assign ram_addr1_o   = wr1_req_addr_i;
  assign ram_w1_data_o = wr1_req_data_i;

  // In-flight flag and round-robin history; clearing the flag drops pre-reset read data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inflight_r   <= 1'b0;
      last_grant_r <= grant_wr_lp;
    end else begin
      inflight_r <= rd_win_s;
      if (rd_win_s) begin
        last_grant_r <= grant_rd_lp;
      end else if (wr_win_s) begin
        last_grant_r <= grant_wr_lp;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  ram_resp_fifo #(
    .width_p (width_p),
    .els_p   (resp_els_p)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (inflight_r),
    .data_i  (ram_r0_data_i),
    .yumi_i  (rd_resp_rdy_i),
    .v_o     (rd_resp_val_o),
    .data_o  (rd_resp_data_o),
    .count_o (fifo_count_s)
  );

endmodule

// File: tb/tb_ram_1rw1w_port_ctrl.sv
// Bench for ram_1rw1w_port_ctrl: behavioural RAM, transaction-level reference model,
// directed scenarios and a randomized soak.
module tb_ram_1rw1w_port_ctrl;

  localparam int W    = 8;
  localparam int ELS  = 16;
  localparam int RESP = 4;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          rd_req_val_i, rd_req_rdy_o;
  logic [AW-1:0] rd_req_addr_i;
  logic          wr0_req_val_i, wr0_req_rdy_o;
  logic [AW-1:0] wr0_req_addr_i;
  logic [W-1:0]  wr0_req_data_i;
  logic          wr1_req_val_i, wr1_req_rdy_o;
  logic [AW-1:0] wr1_req_addr_i;
  logic [W-1:0]  wr1_req_data_i;
  logic          rd_resp_val_o, rd_resp_rdy_i;
  logic [W-1:0]  rd_resp_data_o;
  logic          ram_v0_o, ram_w0_o, ram_v1_o, ram_w1_o;
  logic [AW-1:0] ram_addr0_o, ram_addr1_o;
  logic [W-1:0]  ram_w0_data_o, ram_w1_data_o, ram_r0_data;
  logic          boot;

  int n_cmp = 0;
  int n_err = 0;

  ram_1rw1w_port_ctrl #(.width_p(W), .els_p(ELS), .resp_els_p(RESP)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .rd_req_val_i(rd_req_val_i), .rd_req_rdy_o(rd_req_rdy_o), .rd_req_addr_i(rd_req_addr_i),
    .wr0_req_val_i(wr0_req_val_i), .wr0_req_rdy_o(wr0_req_rdy_o),
    .wr0_req_addr_i(wr0_req_addr_i), .wr0_req_data_i(wr0_req_data_i),
    .wr1_req_val_i(wr1_req_val_i), .wr1_req_rdy_o(wr1_req_rdy_o),
    .wr1_req_addr_i(wr1_req_addr_i), .wr1_req_data_i(wr1_req_data_i),
    .rd_resp_val_o(rd_resp_val_o), .rd_resp_rdy_i(rd_resp_rdy_i), .rd_resp_data_o(rd_resp_data_o),
    .ram_v0_o(ram_v0_o), .ram_w0_o(ram_w0_o), .ram_addr0_o(ram_addr0_o),
    .ram_w0_data_o(ram_w0_data_o), .ram_r0_data_i(ram_r0_data),
    .ram_v1_o(ram_v1_o), .ram_w1_o(ram_w1_o), .ram_addr1_o(ram_addr1_o),
    .ram_w1_data_o(ram_w1_data_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] seed(input int i);
    return W'(i * 37 + 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two-port synchronous RAM: read returns pre-write contents, port 1 applied last.
  logic [W-1:0] ram_mem [ELS];
  always @(posedge clk) begin
    if (boot) begin
      for (int i = 0; i < ELS; i++) ram_mem[i] <= seed(i);
    end else begin
      if (ram_v0_o && !ram_w0_o) ram_r0_data <= ram_mem[ram_addr0_o];
      if (ram_v0_o && ram_w0_o) ram_mem[ram_addr0_o] <= ram_w0_data_o;
      if (ram_v1_o && ram_w1_o) ram_mem[ram_addr1_o] <= ram_w1_data_o;
    end
  end

  // Reference model: memory image plus queue of promised responses with due cycles.
  typedef struct { logic [W-1:0] data; int due; } resp_t;
  resp_t        q[$];
  logic [W-1:0] model_mem [ELS];
  bit           m_last_wr;
  int           cyc = 0;

  always @(negedge clk) begin
    bit e_elig, e_rd, e_wr, e_val;
    cyc++;
    if (reset_i) begin
      q.delete();
      m_last_wr = 1'b1;
      if (boot) for (int i = 0; i < ELS; i++) model_mem[i] = seed(i);
    end else begin
      e_elig = rd_req_val_i && (q.size() < RESP);
      e_rd   = e_elig && (!wr0_req_val_i || m_last_wr);
      e_wr   = wr0_req_val_i && !e_rd;
      e_val  = (q.size() > 0) && (q[0].due <= cyc);
      check("rd_req_rdy", rd_req_rdy_o, e_rd);
      check("wr0_req_rdy", wr0_req_rdy_o, e_wr);
      check("wr1_req_rdy", wr1_req_rdy_o, 1);
      check("ram_v0", ram_v0_o, e_rd | e_wr);
      check("ram_w0", ram_w0_o, e_wr);
      check("ram_v1", ram_v1_o, wr1_req_val_i);
      check("rd_resp_val", rd_resp_val_o, e_val);
      if (e_val) check("rd_resp_data", rd_resp_data_o, q[0].data);
      if (e_val && rd_resp_rdy_i) void'(q.pop_front());
      if (e_rd) begin
        q.push_back('{data: model_mem[rd_req_addr_i], due: cyc + 2});
        m_last_wr = 1'b0;
      end
      if (e_wr) begin
        model_mem[wr0_req_addr_i] = wr0_req_data_i;
        m_last_wr = 1'b1;
      end
      if (wr1_req_val_i) model_mem[wr1_req_addr_i] = wr1_req_data_i;
    end
  end

  task automatic idle_inputs();
    rd_req_val_i  = 1'b0;
    wr0_req_val_i = 1'b0;
    wr1_req_val_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    int n_pop, n_acc;
    bit last_rdy;
    boot = 1'b1;
    reset_i = 1'b1;
    rd_resp_rdy_i = 1'b1;
    rd_req_addr_i = '0; wr0_req_addr_i = '0; wr1_req_addr_i = '0;
    wr0_req_data_i = '0; wr1_req_data_i = '0;
    idle_inputs();
    repeat (3) tick();
    boot = 1'b0;
    reset_i = 1'b0;
    @(negedge clk);
    check("reset_resp_val", rd_resp_val_o, 0);
    check("reset_ram_v0", ram_v0_o, 0);
    tick();

    // Write 0xA5 to addr 3 via port 0, then read it back.
    wr0_req_val_i = 1'b1; wr0_req_addr_i = 4'd3; wr0_req_data_i = 8'hA5;
    @(negedge clk); check("t1_wr0_rdy", wr0_req_rdy_o, 1); tick();
    wr0_req_val_i = 1'b0; rd_req_val_i = 1'b1; rd_req_addr_i = 4'd3;
    @(negedge clk); check("t1_rd_rdy", rd_req_rdy_o, 1); tick();
    rd_req_val_i = 1'b0;
    @(negedge clk); check("t1_not_early", rd_resp_val_o, 0); tick();
    @(negedge clk); check("t1_val", rd_resp_val_o, 1); check("t1_data", rd_resp_data_o, 8'hA5); tick();

    // Back-to-back reads of addresses 0..7.
    n_pop = 0;
    for (int i = 0; i < 12; i++) begin
      rd_req_val_i = (i < 8); rd_req_addr_i = AW'(i);
      @(negedge clk);
      if (i < 8) check("t2_rd_rdy_steady", rd_req_rdy_o, 1);
      if (rd_resp_val_o && rd_resp_rdy_i) n_pop++;
      tick();
    end
    check("t2_resp_count", n_pop, 8);

    // Backpressure: exactly RESP reads fit before the credit stall.
    rd_resp_rdy_i = 1'b0; n_acc = 0; last_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_req_val_i = 1'b1; rd_req_addr_i = AW'(i + 4);
      @(negedge clk);
      if (rd_req_rdy_o) n_acc++;
      last_rdy = rd_req_rdy_o;
      tick();
    end
    check("t3_accepted", n_acc, 4);
    check("t3_rdy_stalled", last_rdy, 0);
    rd_req_val_i = 1'b0; rd_resp_rdy_i = 1'b1; n_pop = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_resp_val_o) n_pop++;
      tick();
    end
    check("t3_drained", n_pop, 4);

    // Continuous contention after reset alternates R,W,R,W...
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rd_req_val_i = 1'b1; rd_req_addr_i = AW'(i);
      wr0_req_val_i = 1'b1; wr0_req_addr_i = AW'(8 + i); wr0_req_data_i = W'(8'h40 + i);
      @(negedge clk);
      check("t4_rd_grant", rd_req_rdy_o, (i % 2 == 0));
      check("t4_wr_grant", wr0_req_rdy_o, (i % 2 == 1));
      tick();
    end
    idle_inputs();
    repeat (4) tick();

    // Same-cycle read and port-1 write to the same address returns old data.
    wr1_req_val_i = 1'b1; wr1_req_addr_i = 4'd5; wr1_req_data_i = 8'h11; tick();
    rd_req_val_i = 1'b1; rd_req_addr_i = 4'd5; wr1_req_data_i = 8'h22; tick();
    idle_inputs(); tick();
    @(negedge clk); check("t5_old_val", rd_resp_val_o, 1); check("t5_old_data", rd_resp_data_o, 8'h11); tick();
    rd_req_val_i = 1'b1; rd_req_addr_i = 4'd5; tick();
    rd_req_val_i = 1'b0; tick();
    @(negedge clk); check("t5_new_val", rd_resp_val_o, 1); check("t5_new_data", rd_resp_data_o, 8'h22); tick();

    // Reset with two queued responses and one read in flight.
    rd_resp_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_req_val_i = 1'b1; rd_req_addr_i = AW'(i + 1);
      @(negedge clk); check("t6_rd_rdy", rd_req_rdy_o, 1); tick();
    end
    rd_req_val_i = 1'b0; reset_i = 1'b1; tick();
    reset_i = 1'b0; rd_resp_rdy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("t6_no_stale", rd_resp_val_o, 0); tick();
    end

    // Randomized soak against the model.
    for (int i = 0; i < 3000; i++) begin
      rd_req_val_i   = ($urandom_range(0, 99) < 60);
      rd_req_addr_i  = AW'($urandom_range(0, ELS - 1));
      wr0_req_val_i  = ($urandom_range(0, 99) < 40);
      wr0_req_addr_i = AW'($urandom_range(0, ELS - 1));
      wr0_req_data_i = W'($urandom);
      wr1_req_val_i  = ($urandom_range(0, 99) < 30);
      wr1_req_addr_i = AW'($urandom_range(0, ELS - 1));
      wr1_req_data_i = W'($urandom);
      rd_resp_rdy_i  = ($urandom_range(0, 99) < 70);
      tick();
    end
    idle_inputs(); rd_resp_rdy_i = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("final_drained", rd_resp_val_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
